// File: rtl/seq_detector_1010_fsm.sv
// rtl/seq_detector_1010_fsm.sv - Moore FSM flagging each 1-0-1-0 in a serial bit stream
//
// Purpose:
//   Watches one serial bit per clock and raises a registered one-cycle flag
//   each time the sequence 1,0,1,0 (first bit received first) completes.
//   OVERLAP=1 lets the trailing "10" of a match seed the next match;
//   OVERLAP=0 restarts detection from scratch after every match.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous reset, active HIGH despite the name
//   x      in   1  serial data bit, sampled on every rising edge
//   z      out  1  match flag, high for one full cycle per detected 1010

module seq_detector_1010_fsm #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic z
);

  // Binary encoding; codes 5..7 are unused and fall back to S_IDLE.
  localparam logic [2:0] S_IDLE  = 3'd0;  // no useful prefix
  localparam logic [2:0] S_1     = 3'd1;  // seen "1"
  localparam logic [2:0] S_10    = 3'd2;  // seen "10"
  localparam logic [2:0] S_101   = 3'd3;  // seen "101"
  localparam logic [2:0] S_MATCH = 3'd4;  // seen "1010"

  logic [2:0] state;
  logic [2:0] state_nxt;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = x ? S_1   : S_IDLE;
      S_1:     state_nxt = x ? S_1   : S_10;
      S_10:    state_nxt = x ? S_101 : S_IDLE;
      // "1011" still ends in a usable "1".
      S_101:   state_nxt = x ? S_1   : S_MATCH;
      // With overlap, "1010" followed by "1" already holds "101".
      S_MATCH: begin
        if (x) begin
          state_nxt = OVERLAP ? S_101 : S_1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // z is its own flop loaded from the next-state decode so the output never
  // sees decode glitches from multi-bit state transitions.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= S_IDLE;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= (state_nxt == S_MATCH);
    end
  end

endmodule

// File: tb/tb_seq_detector_1010_fsm.sv
// tb/tb_seq_detector_1010_fsm.sv - self-checking bench for seq_detector_1010_fsm

module tb_seq_detector_1010_fsm;

  logic clk;
  logic rst_n;
  logic x;
  logic z_ov;
  logic z_no;

  int errors;
  int checks;

  // Reference state: last four bits and bit counts since reset / last match.
  logic [3:0] hist;
  int         n_ov;
  int         n_no;
  int         pulses_ov;
  int         pulses_no;

  seq_detector_1010_fsm #(.OVERLAP(1'b1)) u_dut_ov (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .z     (z_ov)
  );

  seq_detector_1010_fsm #(.OVERLAP(1'b0)) u_dut_no (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .z     (z_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = 4'b0000;
    n_ov = 0;
    n_no = 0;
  endtask

  // Called 1 time unit after a posedge; leaves the bench 1 unit after the next posedge.
  task automatic drive_bit(input logic b, input string tag);
    logic exp_ov;
    logic exp_no;
    @(negedge clk);
    x = b;
    @(posedge clk);
    #1;
    hist = {hist[2:0], b};
    n_ov++;
    n_no++;
    exp_ov = (n_ov >= 4) && (hist == 4'b1010);
    exp_no = (n_no >= 4) && (hist == 4'b1010);
    if (exp_no) n_no = 0;
    check({tag, "_ov"}, int'(z_ov), int'(exp_ov));
    check({tag, "_no"}, int'(z_no), int'(exp_no));
    if (z_ov) pulses_ov++;
    if (z_no) pulses_no++;
  endtask

  task automatic feed(input logic [31:0] bits, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) drive_bit(bits[i], tag);
  endtask

  // Asserts reset mid-cycle (between edges), holds it across one posedge,
  // then releases it just after that posedge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b1;
    #1;
    check({tag, "_async_ov"}, int'(z_ov), 0);
    check({tag, "_async_no"}, int'(z_no), 0);
    @(posedge clk);
    #1;
    check({tag, "_held_ov"}, int'(z_ov), 0);
    check({tag, "_held_no"}, int'(z_no), 0);
    rst_n = 1'b0;
    model_reset();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    pulses_ov = 0;
    pulses_no = 0;
    rst_n     = 1'b1;
    x         = 1'b0;
    model_reset();

    // Reset held with x toggling: z must stay low.
    #1;
    check("por_ov", int'(z_ov), 0);
    check("por_no", int'(z_no), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x = ~x;
      @(posedge clk);
      #1;
      check("rst_hold_ov", int'(z_ov), 0);
      check("rst_hold_no", int'(z_no), 0);
    end
    rst_n = 1'b0;

    // Single match: 0,1,0,1,0,0.
    pulses_ov = 0;
    pulses_no = 0;
    feed(32'b010100, 6, "single");
    check("single_cnt_ov", pulses_ov, 1);
    check("single_cnt_no", pulses_no, 1);

    // Overlap stream: pulses after bits 5,7,13,15 (overlap) and 5,13 (restart).
    do_reset("pre_ovl");
    pulses_ov = 0;
    pulses_no = 0;
    feed(32'b110101011101010, 15, "ovl");
    check("ovl_cnt_ov", pulses_ov, 4);
    check("ovl_cnt_no", pulses_no, 2);

    // Near misses.
    do_reset("pre_near");
    pulses_ov = 0;
    pulses_no = 0;
    feed(32'b1001011011, 10, "near");
    check("near_cnt_ov", pulses_ov, 0);
    check("near_cnt_no", pulses_no, 0);

    // Get into S_MATCH, then reset asynchronously while z is high.
    do_reset("pre_async");
    feed(32'b1010, 4, "async_setup");
    check("async_zhigh_ov", int'(z_ov), 1);
    check("async_zhigh_no", int'(z_no), 1);
    do_reset("mid_match");

    // Reset mid-pattern discards the prefix.
    pulses_ov = 0;
    pulses_no = 0;
    feed(32'b101, 3, "midrst_a");
    do_reset("midrst");
    drive_bit(1'b0, "midrst_b");
    check("midrst_cnt_ov", pulses_ov, 0);
    check("midrst_cnt_no", pulses_no, 0);
    feed(32'b1010, 4, "midrst_c");
    check("midrst_after_ov", pulses_ov, 1);
    check("midrst_after_no", pulses_no, 1);

    // Randomized stream, biased toward 1010-like data, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) begin
        do_reset("rnd_rst");
      end else if ($urandom_range(3) == 0) begin
        feed(32'b1010, 4, "rnd_pat");
      end else begin
        drive_bit(1'($urandom_range(1)), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
